// File: rtl/axis_acq_trigger_packer_if.sv
// axis_acq_trigger_packer_if: AXI-Stream bundle shared by the packer's sample input and word output
interface axis_acq_trigger_packer_if #(
   parameter int W = 32
);
   logic [W-1:0] tdata;
   logic         tvalid;
   logic         tready;
   logic         tlast;
   modport master (output tdata, tvalid, tlast, input tready);
   modport slave  (input tdata, tvalid, output tready);
endinterface

// File: rtl/axis_acq_trigger_packer.sv
// axis_acq_trigger_packer: armed, edge-triggered ADC capture packing beat pairs into 2x-wide AXI-Stream words
module axis_acq_trigger_packer #(
   parameter int S_TDATA_WIDTH = 32,
   parameter int CNTR_WIDTH    = 32
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic                  arm,
   input  logic                  trig,
   input  logic [CNTR_WIDTH-1:0] cfg_len,
   output logic [1:0]            sts_state,
   output logic [CNTR_WIDTH-1:0] sts_count,
   output logic                  sts_overflow,
   axis_acq_trigger_packer_if.slave  s_axis,
   axis_acq_trigger_packer_if.master m_axis
);
   typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
   state_t                     r_state, w_state_nxt;
   logic                       r_trig_d, r_phase, r_ovf, r_tvalid, r_tlast;
   logic [S_TDATA_WIDTH-1:0]   r_lo;
   logic [2*S_TDATA_WIDTH-1:0] r_tdata;
   logic [CNTR_WIDTH-1:0]      r_len, r_count, w_cnt_nxt;
   logic                       w_edge, w_hs, w_arm, w_take, w_word, w_load;

   assign w_edge    = trig & ~r_trig_d;
   assign w_hs      = r_tvalid & m_axis.tready;
   assign w_cnt_nxt = r_count + CNTR_WIDTH'(1);

   always_ff @(posedge aclk)
      r_state <= areset ? IDLE : w_state_nxt;

   always_comb begin
      w_state_nxt = w_arm ? ARMED :
                    (r_state == ARMED && w_edge) ? CAPTURE :
                    (r_state == CAPTURE && w_hs && r_tlast) ? DONE : r_state;
   end

   // The edge-cycle beat is captured straight from ARMED unless a re-arm wins that cycle
   always_comb begin
      w_arm  = arm && r_state != CAPTURE;
      w_take = s_axis.tvalid && ((r_state == CAPTURE && r_count != r_len) ||
                                 (r_state == ARMED && w_edge && !arm));
      w_word = w_take & r_phase;
      w_load = w_word & (~r_tvalid | m_axis.tready);
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         r_trig_d <= 1'b0;
         r_phase  <= 1'b0;
         r_ovf    <= 1'b0;
         r_tvalid <= 1'b0;
         r_tlast  <= 1'b0;
         r_count  <= '0;
         r_len    <= CNTR_WIDTH'(1);
      end else begin
         r_trig_d <= trig;
         r_tvalid <= w_load | (r_tvalid & ~m_axis.tready);
         if (w_take) r_phase <= ~r_phase;
         if (w_take & ~r_phase) r_lo <= s_axis.tdata;
         if (w_word & ~w_load) r_ovf <= 1'b1;
         if (w_load) begin
            r_tdata <= {s_axis.tdata, r_lo};
            r_tlast <= w_cnt_nxt == r_len;
            r_count <= w_cnt_nxt;
         end else if (w_hs) begin
            r_tlast <= 1'b0;
         end
         if (w_arm) begin
            r_phase <= 1'b0;
            r_ovf   <= 1'b0;
            r_count <= '0;
            r_len   <= (cfg_len == '0) ? CNTR_WIDTH'(1) : cfg_len;
         end
      end
   end

   assign s_axis.tready = 1'b1;
   assign m_axis.tdata  = r_tdata;
   assign m_axis.tvalid = r_tvalid;
   assign m_axis.tlast  = r_tlast;
   assign sts_state     = r_state;
   assign sts_count     = r_count;
   assign sts_overflow  = r_ovf;
endmodule
